instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
Consumer side of the fetch-address stream produced by the program counter. Accepts fetch addresses, issues in-order read requests to instruction memory, and buffers returned instructions with their PCs in a small queue. Presents {pc, instr} pairs to decode over a valid/ready handshake. Discards all queued and in-flight fetches on a branch flush.

Parameters:
PC_WIDTH, 16, width of fetch addresses; matches the program counter.
INSTR_WIDTH, 32, instruction word width.
DEPTH, 4, queue entries and maximum in-flight requests; power of two, ≥2.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
pc_in  input  PC_WIDTH  fetch address from program counter
pc_valid  input  1  pc_in valid
pc_ready  output  1  fetch address accepted this cycle
flush  input  1  branch taken; drop all pending fetches
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  PC_WIDTH  request address (= pc_in)
mem_rsp_valid  input  1  read data valid, in request order
mem_rsp_data  input  INSTR_WIDTH  instruction word
dec_valid  output  1  dec_instr/dec_pc valid
dec_ready  input  1  decode accepts entry
dec_instr  output  INSTR_WIDTH  instruction
dec_pc  output  PC_WIDTH  PC of dec_instr

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All pointers, counters and drop counter cleared. dec_valid=0, mem_req_valid=0, pc_ready=0 while rst is high. dec_instr/dec_pc = 0.
- Credits: credit_ok = (occupancy + outstanding) < DEPTH. occupancy counts buffered entries. outstanding counts issued requests without a response, excluding dropped ones.
- Request path is combinational pass-through:
  - mem_req_valid = pc_valid & credit_ok & ~flush.
  - pc_ready = mem_req_ready & credit_ok & ~flush.
  - mem_req_addr = pc_in.
  - Issue occurs when mem_req_valid & mem_req_ready; the PC is pushed into the PC FIFO at issue.
- Response path:
  - If drop_cnt > 0, mem_rsp_valid decrements drop_cnt and the data is discarded.
  - Otherwise the data is paired with the PC FIFO head and written to the instruction queue. The entry becomes visible to decode the next cycle: 1-cycle latency from response to dec_valid.
- Decode handshake:
  - dec_valid = occupancy > 0; outputs come from the queue head.
  - Pop on dec_valid & dec_ready.
  - dec_instr/dec_pc hold stable while dec_valid & ~dec_ready.
- Simultaneous response write and decode pop on a non-empty queue: both occur, occupancy unchanged.
- Full: credits guarantee a response can never overflow the queue. The queue asserts no separate ready to memory; memory has no back-pressure on responses.
- Wrap-around: pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = MSB differs and indices equal.
- Flush, registered at the clock edge:
  - occupancy and PC FIFO cleared.
  - drop_cnt <= outstanding, minus 1 if a non-dropped response arrives that same cycle.
  - outstanding <= 0.
  - Requests are blocked during the flush cycle. dec_valid falls to 0 the following cycle.
  - Flush while drop_cnt > 0 adds the new outstanding count to drop_cnt.
- Widths: counters are log2(DEPTH)+1 bits. drop_cnt never exceeds DEPTH.
- Async reset mid-transfer: all state cleared immediately. Responses for requests issued before reset must not be delivered; memory is reset by the same rst.

Optional Feature:
- IFQ_BYPASS_EN defined: when the queue is empty, a non-dropped response presents combinationally on dec_instr/dec_pc with dec_valid=1 in the same cycle. If dec_ready is also high, the word is consumed without being written. Zero-cycle response-to-decode latency.
- Undefined: fixed 1-cycle latency as described above. No combinational path from mem_rsp_* to dec_*.

Decomposition:
- Package ifq_pkg: typedef ifq_entry_t struct {pc, instr}; constant IFQ_PTR_W = $clog2(DEPTH)+1 as a function of DEPTH; defaults for PC_WIDTH/INSTR_WIDTH.
- Sub-module ifq_fifo: generic synchronous FIFO (push, pop, clear, full, empty, count). It is instantiated twice: once for the PC FIFO and once for the entry queue.

Test Plan:
- Streaming: pc_in 0x0000,0x0004,0x0008; memory latency 2 cycles, dec_ready=1 → dec_pc 0/4/8 with the matching instrs, in order, each 1 cycle after its response.
- Back-pressure: dec_ready=0, DEPTH=4, pc_valid held → exactly 4 requests issued, then pc_ready=0; one dec pop re-opens exactly one credit.
- Flush with 2 outstanding and 1 buffered: flush pulse → dec_valid=0 next cycle, next 2 responses discarded; a new fetch at 0x0040 returns dec_pc=0x0040 first.
- Flush coincident with a response and with pc_valid → no request issued that cycle, response dropped, drop_cnt correct.
- Async reset asserted mid-burst between clock edges → outputs cleared immediately; after release the first fetch 0x0000 completes normally.
- Simultaneous push/pop on an occupancy=2 queue for 10 cycles → occupancy stays 2, order preserved; repeat with IFQ_BYPASS_EN: empty-queue response seen on dec_* in the same cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and sizing helpers for the instruction fetch queue.
// The IFQ_BYPASS_EN macro (see instr_fetch_queue) does not affect this package.
package ifq_pkg;

  localparam int IFQ_PC_WIDTH    = 16;
  localparam int IFQ_INSTR_WIDTH = 32;
  localparam int IFQ_DEPTH       = 4;

  typedef struct packed {
    logic [IFQ_PC_WIDTH-1:0]    pc;
    logic [IFQ_INSTR_WIDTH-1:0] instr;
  } ifq_entry_t;

  // Pointers and counters carry one extra bit so full and empty can be told apart.
  function automatic int ifq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, synchronous clear and an occupancy count.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = ifq_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] count_o
);

  localparam int IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                   (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q[IDX_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; reads of an empty FIFO are masked by the user.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-address consumer: issues in-order memory reads, queues {pc, instr} for decode, drops fetches on flush.
// Define IFQ_BYPASS_EN to let a response reach decode in the same cycle when the queue is empty.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int PC_WIDTH    = IFQ_PC_WIDTH,
  parameter int INSTR_WIDTH = IFQ_INSTR_WIDTH,
  parameter int DEPTH       = IFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  input  logic                   flush,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PC_WIDTH-1:0]    mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [PC_WIDTH-1:0]    dec_pc
);

  localparam int PTR_W = ifq_ptr_w(DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [PTR_W-1:0]    drop_q, drop_d;
  logic [PTR_W-1:0]    outstanding;
  logic [PTR_W-1:0]    occupancy;
  logic [PC_WIDTH-1:0] pc_head;
  logic                pc_empty, pc_full;
  entry_t              q_head, q_wr;
  logic                q_empty, q_full;
  logic                q_push, q_pop;
  logic                credit_ok, issue;
  logic                rsp_drop, rsp_live;
  logic                unused_full;

  assign unused_full = pc_full | q_full;

  // The PC FIFO holds exactly the live in-flight requests, so its count is the outstanding credit.
  assign credit_ok     = ({1'b0, occupancy} + {1'b0, outstanding}) < (PTR_W+1)'(DEPTH);
  assign mem_req_valid = ~rst & pc_valid & credit_ok & ~flush;
  assign pc_ready      = ~rst & mem_req_ready & credit_ok & ~flush;
  assign mem_req_addr  = pc_in;
  assign issue         = mem_req_valid & mem_req_ready;

  assign rsp_drop = mem_rsp_valid & (drop_q != '0);
  assign rsp_live = mem_rsp_valid & (drop_q == '0) & ~pc_empty;
  assign q_wr     = '{pc: pc_head, instr: mem_rsp_data};
  assign q_pop    = dec_ready & ~q_empty;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_live & q_empty & ~flush & ~rst;
  assign q_push    = rsp_live & ~flush & ~(bypass & dec_ready);
  assign dec_valid = ~q_empty | bypass;
  assign dec_pc    = !q_empty ? q_head.pc    : (bypass ? pc_head      : '0);
  assign dec_instr = !q_empty ? q_head.instr : (bypass ? mem_rsp_data : '0);
`else
  assign q_push    = rsp_live & ~flush;
  assign dec_valid = ~q_empty;
  assign dec_pc    = q_empty ? '0 : q_head.pc;
  assign dec_instr = q_empty ? '0 : q_head.instr;
`endif

  // On flush every live in-flight request becomes a response to discard.
  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      drop_d = drop_q + outstanding - PTR_W'(rsp_drop) - PTR_W'(rsp_live);
    end else if (rsp_drop) begin
      drop_d = drop_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  ifq_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .data_i  (pc_in),
    .pop_i   (rsp_live),
    .clear_i (flush),
    .data_o  (pc_head),
    .full_o  (pc_full),
    .empty_o (pc_empty),
    .count_o (outstanding)
  );

  ifq_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .data_i  (q_wr),
    .pop_i   (q_pop),
    .clear_i (flush),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occupancy)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios followed by random traffic against a queue-level model.
// The reference model follows IFQ_BYPASS_EN when the macro is defined.
module tb_instr_fetch_queue;
  import ifq_pkg::*;

  localparam int PCW   = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [PCW-1:0]  pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [PCW-1:0]  mem_req_addr;
  logic            mem_rsp_valid;
  logic [IW-1:0]   mem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [IW-1:0]   dec_instr;
  logic [PCW-1:0]  dec_pc;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc)
  );

  // In-flight request as seen by both the memory and the model: address, discard mark, earliest reply cycle.
  typedef struct {
    logic [PCW-1:0] pc;
    bit             dropped;
    int             due;
  } flight_t;

  flight_t        flight[$];
  ifq_entry_t     decQ[$];
  logic [PCW-1:0] dutPops[$];

  int  cycleNo, latency, dutIssue, checkCnt, passCnt, failCnt;
  bit  rspAllow;
  bit  expReqValid, expPcReady, expDecValid, rspLive, bypassTake;
  logic [PCW-1:0] expDecPc;
  logic [IW-1:0]  expDecInstr;
  logic           lastPcReady;
  int  idx, nDrop;

  function automatic logic [IW-1:0] instrOf(input logic [PCW-1:0] a);
    return {~a, a} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] popAt(input int k);
    if (k < dutPops.size()) return 32'(dutPops[k]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit pv, input logic [PCW-1:0] pin, input bit fl,
                               input bit rr, input bit dr);
    pc_valid      = pv;
    pc_in         = pin;
    flush         = fl;
    mem_req_ready = rr;
    dec_ready     = dr;
    if (flight.size() > 0 && flight[0].due <= cycleNo && rspAllow) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instrOf(flight[0].pc);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  endtask

  // Predicts the combinational outputs from queue contents and compares them at the negedge.
  task automatic checkOutput();
    int live = 0;
    bit credit;
    foreach (flight[i]) if (!flight[i].dropped) live++;
    credit      = (decQ.size() + live) < DEPTH;
    expReqValid = pc_valid && credit && !flush;
    expPcReady  = mem_req_ready && credit && !flush;
    rspLive     = mem_rsp_valid && flight.size() > 0 && !flight[0].dropped;
    expDecValid = decQ.size() > 0;
    expDecPc    = '0;
    expDecInstr = '0;
    bypassTake  = 1'b0;
    if (decQ.size() > 0) begin
      expDecPc    = decQ[0].pc;
      expDecInstr = decQ[0].instr;
    end
`ifdef IFQ_BYPASS_EN
    if (decQ.size() == 0 && rspLive && !flush) begin
      expDecValid = 1'b1;
      expDecPc    = flight[0].pc;
      expDecInstr = mem_rsp_data;
      bypassTake  = dec_ready;
    end
`endif
    check("mem_req_valid", 32'(mem_req_valid), 32'(expReqValid));
    check("pc_ready",      32'(pc_ready),      32'(expPcReady));
    check("mem_req_addr",  32'(mem_req_addr),  32'(pc_in));
    check("dec_valid",     32'(dec_valid),     32'(expDecValid));
    check("dec_pc",        32'(dec_pc),        32'(expDecPc));
    check("dec_instr",     dec_instr,          expDecInstr);
    lastPcReady = pc_ready;
    if (mem_req_valid && mem_req_ready) dutIssue++;
    if (dec_valid && dec_ready) dutPops.push_back(dec_pc);
  endtask

  task automatic advance();
    flight_t f;
    @(posedge clk);
    if (decQ.size() > 0 && dec_ready) void'(decQ.pop_front());
    if (mem_rsp_valid) begin
      f = flight.pop_front();
      if (!f.dropped && !flush && !bypassTake)
        decQ.push_back('{pc: f.pc, instr: mem_rsp_data});
    end
    if (flush) begin
      decQ.delete();
      foreach (flight[i]) flight[i].dropped = 1'b1;
    end
    if (expReqValid && mem_req_ready)
      flight.push_back('{pc: pc_in, dropped: 1'b0, due: cycleNo + latency});
    cycleNo++;
    #1;
  endtask

  task automatic cycle(input bit pv, input logic [PCW-1:0] pin, input bit fl,
                       input bit rr, input bit dr);
    applyStimulus(pv, pin, fl, rr, dr);
    @(negedge clk);
    checkOutput();
    advance();
  endtask

  initial begin
    checkCnt = 0; passCnt = 0; failCnt = 0; cycleNo = 0; dutIssue = 0;
    latency = 2; rspAllow = 1'b1;
    rst = 1'b1; pc_valid = 1'b1; pc_in = 16'h0010; flush = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; dec_ready = 1'b1;

    @(posedge clk); @(negedge clk);
    check("reset_dec_valid",     32'(dec_valid),     32'd0);
    check("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset_pc_ready",      32'(pc_ready),      32'd0);
    check("reset_dec_pc",        32'(dec_pc),        32'd0);
    check("reset_dec_instr",     dec_instr,          32'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] streaming");
    idx = dutPops.size();
    cycle(1, 16'h0000, 0, 1, 1);
    cycle(1, 16'h0004, 0, 1, 1);
    cycle(1, 16'h0008, 0, 1, 1);
    repeat (6) cycle(0, 16'h0000, 0, 1, 1);
    check("stream_pop0", popAt(idx),   32'h0000);
    check("stream_pop1", popAt(idx+1), 32'h0004);
    check("stream_pop2", popAt(idx+2), 32'h0008);

    $display("[TB] back-pressure");
    dutIssue = 0;
    for (int i = 0; i < 10; i++) cycle(1, 16'(16'h0100 + 4*i), 0, 1, 0);
    check("bp_issue_count", 32'(dutIssue), 32'd4);
    check("bp_pc_ready",    32'(lastPcReady), 32'd0);
    cycle(0, 16'h0000, 0, 1, 1);
    dutIssue = 0;
    for (int i = 0; i < 4; i++) cycle(1, 16'(16'h0180 + 4*i), 0, 1, 0);
    check("bp_one_credit", 32'(dutIssue), 32'd1);
    repeat (10) cycle(0, 16'h0000, 0, 1, 1);

    $display("[TB] flush with buffered and outstanding");
    cycle(1, 16'h0200, 0, 1, 0);
    cycle(0, 16'h0000, 0, 1, 0);
    cycle(0, 16'h0000, 0, 1, 0);
    rspAllow = 1'b0;
    cycle(1, 16'h0204, 0, 1, 0);
    cycle(1, 16'h0208, 0, 1, 0);
    cycle(0, 16'h0000, 1, 1, 0);
    rspAllow = 1'b1;
    idx = dutPops.size();
    cycle(1, 16'h0040, 0, 1, 0);
    repeat (8) cycle(0, 16'h0000, 0, 1, 1);
    check("flush_first_pc", popAt(idx), 32'h0040);

    $display("[TB] flush with response and request");
    cycle(1, 16'h0300, 0, 1, 0);
    cycle(1, 16'h0304, 0, 1, 0);
    cycle(1, 16'h0308, 1, 1, 0);
    idx = dutPops.size();
    cycle(1, 16'h030C, 0, 1, 1);
    repeat (8) cycle(0, 16'h0000, 0, 1, 1);
    check("flush_rsp_first_pc", popAt(idx), 32'h030C);
    check("flush_rsp_pops",     32'(dutPops.size() - idx), 32'd1);

    $display("[TB] async reset mid-burst");
    for (int i = 0; i < 5; i++) cycle(1, 16'(16'h0700 + 4*i), 0, 1, (i % 2) == 1);
    applyStimulus(1, 16'h0714, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_dec_valid",     32'(dec_valid),     32'd0);
    check("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("arst_pc_ready",      32'(pc_ready),      32'd0);
    check("arst_dec_pc",        32'(dec_pc),        32'd0);
    check("arst_dec_instr",     dec_instr,          32'd0);
    flight.delete();
    decQ.delete();
    @(posedge clk); #1 rst = 1'b0;
    idx = dutPops.size();
    cycle(1, 16'h0000, 0, 1, 1);
    repeat (6) cycle(0, 16'h0000, 0, 1, 1);
    check("arst_first_pc",   popAt(idx), 32'h0000);
    check("arst_pop_count",  32'(dutPops.size() - idx), 32'd1);

    $display("[TB] simultaneous push and pop");
    idx = dutPops.size();
    cycle(1, 16'h0500, 0, 1, 0);
    cycle(1, 16'h0504, 0, 1, 0);
    cycle(0, 16'h0000, 0, 1, 0);
    cycle(0, 16'h0000, 0, 1, 0);
    latency = 1;
    cycle(1, 16'h0600, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 16'(16'h0604 + 4*i), 0, 1, 1);
    for (int k = 0; k < 10; k++)
      check($sformatf("pushpop_pop%0d", k), popAt(idx + k),
            (k < 2) ? 32'(16'h0500 + 4*k) : 32'(16'h0600 + 4*(k-2)));
    latency = 2;
    repeat (8) cycle(0, 16'h0000, 0, 1, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      nDrop = 0;
      foreach (flight[j]) if (flight[j].dropped) nDrop++;
      rspAllow = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) latency = $urandom_range(1, 3);
      cycle($urandom_range(0, 3) != 0, 16'($urandom) & 16'hFFFC,
            (nDrop == 0) && ($urandom_range(0, 19) == 0),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
